// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub
// Pipelined adder/subtractor. The operand width is split into NSEG segments
// of SEG_WIDTH bits. Each segment is added in its own pipeline stage by a
// carry-lookahead adder that is built from 4-bit generate/propagate groups.
// A result leaves the pipeline NSEG cycles after its operands were accepted.
// The pipeline takes one beat per cycle. A valid/ready handshake on the
// output stalls the whole pipeline at once.
//
// Ports
//   clk        sole clock; all state updates on the rising edge
//   rst_n      asynchronous, active-low reset
//   in_valid   an operand beat is offered this cycle
//   in_ready   the block accepts a beat this cycle (equals the global advance)
//   a_in       operand A (unsigned or two's complement)
//   b_in       operand B
//   c_in       carry-in, or the borrow-in complement when subtracting
//   sub        0: A+B+c_in, 1: A+~B+c_in
//   out_valid  a result beat is present
//   out_ready  downstream takes the result this cycle
//   sum        result bits
//   c_out      carry out of the MSB
//   ovf        signed overflow (carry into MSB xor carry out)
module cla_pipe_addsub #(
   parameter int WIDTH     = 64,
   parameter int SEG_WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int NSEG = WIDTH / SEG_WIDTH;
   localparam int NGRP = (SEG_WIDTH + 3) / 4;

   // This function adds one segment using 4-bit lookahead groups.
   // The return value is {overflow, carry_out, sum}. The overflow bit is the
   // carry into the segment MSB xor the carry out of the segment. It only
   // matters for the top segment.
   function automatic logic [SEG_WIDTH+1:0] seg_add(input logic [SEG_WIDTH-1:0] a,
                                                    input logic [SEG_WIDTH-1:0] b,
                                                    input logic             ci);
      logic [SEG_WIDTH-1:0] g;
      logic [SEG_WIDTH-1:0] p;
      logic [SEG_WIDTH-1:0] s;
      logic                 gc;
      logic                 c;
      logic                 gg;
      logic                 pp;
      logic                 cm;
      g  = a & b;
      p  = a ^ b;
      s  = '0;
      gc = ci;
      cm = ci;
      for (int grp = 0; grp < NGRP; grp++) begin
         c  = gc;
         gg = 1'b0;
         pp = 1'b1;
         for (int j = 0; j < 4; j++) begin
            if (grp * 4 + j < SEG_WIDTH) begin
               s[grp*4+j] = p[grp*4+j] ^ c;
               if (grp * 4 + j == SEG_WIDTH - 1) cm = c;
               c  = g[grp*4+j] | (p[grp*4+j] & c);
               gg = g[grp*4+j] | (p[grp*4+j] & gg);
               pp = pp & p[grp*4+j];
            end
         end
         gc = gg | (pp & gc);
      end
      return {cm ^ gc, gc, s};
   endfunction

   // Stage registers. Each stage keeps its operands right-shifted so that the
   // next segment to add is always in the low SEG_WIDTH bits. The partial sum
   // fills in from the top. After NSEG stages every segment sits in its
   // proper place.
   logic             vld   [NSEG];
   logic [WIDTH-1:0] a_r   [NSEG];
   logic [WIDTH-1:0] b_r   [NSEG];
   logic [WIDTH-1:0] s_r   [NSEG];
   logic             cy_r  [NSEG];
   logic             ov_r  [NSEG];

   logic [WIDTH-1:0] st_a  [NSEG];
   logic [WIDTH-1:0] st_b  [NSEG];
   logic [WIDTH-1:0] st_s  [NSEG];
   logic             st_ci [NSEG];
   logic             nx_vld[NSEG];
   logic [WIDTH-1:0] nx_s  [NSEG];
   logic             nx_cy [NSEG];
   logic             nx_ov [NSEG];

   logic adv;

   // The pipeline moves as one unit. It advances whenever the output
   // register is empty or is being drained this cycle.
   assign adv       = ~vld[NSEG-1] | out_ready;
   assign in_ready  = adv;
   assign out_valid = vld[NSEG-1];
   assign sum       = s_r[NSEG-1];
   assign c_out     = cy_r[NSEG-1];
   assign ovf       = ov_r[NSEG-1];

   // Stage 0 adds straight from the ports and inverts B at capture time.
   // Later stages add from the registers of the stage before them.
   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      logic [SEG_WIDTH+1:0] res;
      if (k == 0) begin : g_head
         assign st_a[k]   = a_in;
         assign st_b[k]   = sub ? ~b_in : b_in;
         assign st_s[k]   = '0;
         assign st_ci[k]  = c_in;
         assign nx_vld[k] = in_valid;
      end else begin : g_tail
         assign st_a[k]   = a_r[k-1];
         assign st_b[k]   = b_r[k-1];
         assign st_s[k]   = s_r[k-1];
         assign st_ci[k]  = cy_r[k-1];
         assign nx_vld[k] = vld[k-1];
      end
      assign res      = seg_add(st_a[k][SEG_WIDTH-1:0], st_b[k][SEG_WIDTH-1:0], st_ci[k]);
      assign nx_s[k]  = (st_s[k] >> SEG_WIDTH)
                      | (WIDTH'(res[SEG_WIDTH-1:0]) << (WIDTH - SEG_WIDTH));
      assign nx_cy[k] = res[SEG_WIDTH];
      assign nx_ov[k] = res[SEG_WIDTH+1];
   end

   // All stage state moves forward together on advance and holds otherwise.
   // Reset clears everything at once, so any beats in flight are discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NSEG; k++) begin
            vld[k]  <= 1'b0;
            a_r[k]  <= '0;
            b_r[k]  <= '0;
            s_r[k]  <= '0;
            cy_r[k] <= 1'b0;
            ov_r[k] <= 1'b0;
         end
      end else if (adv) begin
         for (int k = 0; k < NSEG; k++) begin
            vld[k]  <= nx_vld[k];
            a_r[k]  <= st_a[k] >> SEG_WIDTH;
            b_r[k]  <= st_b[k] >> SEG_WIDTH;
            s_r[k]  <= nx_s[k];
            cy_r[k] <= nx_cy[k];
            ov_r[k] <= nx_ov[k];
         end
      end
   end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub
// Self-checking bench for cla_pipe_addsub (WIDTH=64, SEG_WIDTH=16).
// The stimulus side pushes the expected result of every accepted beat into a
// queue. A separate monitor pops that queue and compares whenever a result is
// handed downstream.
module tb_cla_pipe_addsub;

   localparam int WIDTH     = 64;
   localparam int SEG_WIDTH = 16;
   localparam int NSEG      = WIDTH / SEG_WIDTH;

   typedef logic [WIDTH+1:0] beat_t;
   typedef logic [71:0]      val_t;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a_in      = '0;
   logic [WIDTH-1:0] b_in      = '0;
   logic             c_in      = 1'b0;
   logic             sub       = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;

   int    n_checks = 0;
   int    n_fail   = 0;
   beat_t exp_q[$];

   cla_pipe_addsub #(.WIDTH(WIDTH), .SEG_WIDTH(SEG_WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .c_in(c_in), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .c_out(c_out), .ovf(ovf)
   );

   // Free-running clock with a 10-unit period
   always #5 clk = ~clk;

   // Reference model. It uses plain wide arithmetic, and it decides overflow
   // by sign rules: when both operands have the same sign, the result sign
   // must match that sign.
   function automatic beat_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic ci, input logic sb);
      logic [WIDTH:0]   total;
      logic [WIDTH-1:0] bb;
      logic             ov;
      bb    = sb ? ~b : b;
      total = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
      ov    = (a[WIDTH-1] == bb[WIDTH-1]) && (total[WIDTH-1] != a[WIDTH-1]);
      return {total[WIDTH], ov, total[WIDTH-1:0]};
   endfunction

   function automatic logic [WIDTH-1:0] rand_op();
      case ($urandom_range(0, 7))
         0:       return '1;
         1:       return '0;
         2:       return 64'h8000_0000_0000_0000;
         3:       return 64'h7FFF_FFFF_FFFF_FFFF;
         4:       return 64'h0000_FFFF_FFFF_FFFF;
         5:       return 64'h0000_0000_0000_FFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic check_output(input string name, input val_t act, input val_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one cycle of inputs at the falling edge. If the beat will be
   // accepted at the next rising edge, its model result goes into the queue.
   task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic ci,
                                 input logic sb, input logic ordy, output logic took);
      @(negedge clk);
      in_valid  = v;
      a_in      = a;
      b_in      = b;
      c_in      = ci;
      sub       = sb;
      out_ready = ordy;
      #1;
      took = v && in_ready && rst_n;
      if (took) exp_q.push_back(model(a, b, ci, sb));
   endtask

   task automatic idle(input int n);
      logic took;
      repeat (n) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, took);
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < 50) begin
         idle(1);
         c++;
      end
      idle(2);
   endtask

   // Sends one beat into an empty pipeline with a fixed expected result, then
   // counts the cycles until the result shows up.
   task automatic run_directed(input string name, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic ci,
                               input logic sb, input beat_t exp);
      int cnt;
      @(negedge clk);
      in_valid  = 1'b1;
      a_in      = a;
      b_in      = b;
      c_in      = ci;
      sub       = sb;
      out_ready = 1'b1;
      #1;
      check_output({name, " accept"}, val_t'(in_ready), val_t'(1));
      exp_q.push_back(exp);
      cnt = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         #3;
         cnt++;
      end while (!out_valid && cnt < 20);
      check_output({name, " latency"}, val_t'(cnt), val_t'(NSEG));
      idle(2);
   endtask

   // Monitor. In reset it checks the cleared outputs and empties the queue.
   // Otherwise it checks that outputs hold across a stall, that in_ready
   // follows the advance rule, and that every popped result matches the next
   // expected beat in order.
   initial begin
      logic  prev_stall;
      val_t  prev_out;
      prev_stall = 1'b0;
      prev_out   = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            check_output("reset out_valid", val_t'(out_valid), val_t'(0));
            check_output("reset outputs", val_t'({c_out, ovf, sum}), val_t'(0));
            check_output("reset in_ready", val_t'(in_ready), val_t'(1));
            exp_q.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               check_output("hold under stall", val_t'({out_valid, c_out, ovf, sum}), prev_out);
            check_output("in_ready", val_t'(in_ready), val_t'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("[TB] FAIL unexpected output: got 0x%0h, expected no beat",
                           {c_out, ovf, sum});
               end else begin
                  check_output("result", val_t'({c_out, ovf, sum}), val_t'(exp_q.pop_front()));
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = val_t'({out_valid, c_out, ovf, sum});
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence
   initial begin
      logic took;
      logic pat [12];
      int   idx;
      int   cyc;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Directed vectors, including wraps and both overflow directions
      run_directed("add carry across segments", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                   {1'b0, 1'b0, 64'h0000_0001_0000_0000});
      run_directed("sub 5-7", 64'h5, 64'h7, 1'b1, 1'b1,
                   {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
      run_directed("all-ones wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                   {1'b1, 1'b0, 64'h0});
      run_directed("positive overflow", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                   {1'b0, 1'b1, 64'h8000_0000_0000_0000});
      run_directed("carry-in ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
                   {1'b1, 1'b0, 64'h0});
      run_directed("negative overflow", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1,
                   {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF});

      // Bubbles: alternating valid shows up NSEG cycles later
      drain();
      for (int i = 0; i < 12; i++) begin
         pat[i] = (i < 8) && (i % 2 == 0);
         apply_stimulus(pat[i], rand_op(), rand_op(), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'b1, took);
         #2;
         if (i >= NSEG)
            check_output("bubble out_valid", val_t'(out_valid), val_t'(pat[i-NSEG]));
      end

      // Backpressure: 8 back-to-back beats with a 3-cycle stall mid-stream
      drain();
      idx = 0;
      cyc = 0;
      while (idx < 8 && cyc < 40) begin
         apply_stimulus(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), !(cyc >= 5 && cyc <= 7), took);
         if (cyc >= 5 && cyc <= 7)
            check_output("stall in_ready", val_t'(in_ready), val_t'(0));
         if (took) idx++;
         cyc++;
      end
      check_output("backpressure beats accepted", val_t'(idx), val_t'(8));
      drain();

      // Random traffic with random downstream readiness
      for (int i = 0; i < 400; i++) begin
         apply_stimulus($urandom_range(0, 3) != 0, rand_op(), rand_op(),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 3) != 0, took);
      end
      drain();

      // Reset in flight: three beats are discarded, and a fresh beat still
      // takes NSEG cycles
      for (int i = 0; i < 3; i++)
         apply_stimulus(1'b1, rand_op(), rand_op(), 1'b0, 1'b0, 1'b1, took);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         idle(1);
         #2;
         check_output("no stale beat after reset", val_t'(out_valid), val_t'(0));
      end
      run_directed("post-reset beat", 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020,
                   1'b0, 1'b0, {1'b0, 1'b0, 64'h30});

      drain();
      check_output("leftover beats", val_t'(exp_q.size()), val_t'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cla_pipe_addsub.md
CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 64, operand and result width in bits; SHALL be an integer multiple of SEG_WIDTH.
REQ-002 Parameter SEG_WIDTH, default 16, width of one carry-lookahead segment; each segment occupies one pipeline stage.
REQ-003 Derived constant NSEG = WIDTH/SEG_WIDTH, equal to the pipeline depth and latency in cycles; NSEG >= 1.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand beat offered this cycle.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 a_in  input  WIDTH  operand A, unsigned or two's complement.
REQ-009 b_in  input  WIDTH  operand B.
REQ-010 c_in  input  1  carry-in (add) or borrow-in-complement (subtract).
REQ-011 sub  input  1  0 = A+B+c_in; 1 = A+~B+c_in (A-B when c_in=1).
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts result this cycle.
REQ-014 sum  output  WIDTH  result bits.
REQ-015 c_out  output  1  carry out of bit WIDTH-1.
REQ-016 ovf  output  1  signed overflow: carry into MSB XOR c_out.

Function
REQ-017 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-018 Global advance adv = (~out_valid) | out_ready; in_ready SHALL equal adv combinationally, with no dependency on in_valid.
REQ-019 When adv=0 every stage register, valid bit and output SHALL hold its value.
REQ-020 Stage k (k = 0..NSEG-1) SHALL compute segment k, bits [(k+1)*SEG_WIDTH-1 : k*SEG_WIDTH], with 4-bit-group lookahead generate/propagate inside the segment, using the carry registered by stage k-1 (stage 0 uses c_in).
REQ-021 Segment k operand bits SHALL be delayed k cycles before stage k; completed lower result bits SHALL be carried forward so all WIDTH bits exit aligned.
REQ-022 The B inversion for sub=1 SHALL be applied at input capture; the sub flag is not needed downstream.
REQ-023 Latency SHALL be exactly NSEG cycles from acceptance to out_valid=1, given adv=1 throughout; throughput one beat per cycle.
REQ-024 Each stage SHALL carry a valid bit; bubbles (in_valid=0 at acceptance) SHALL propagate as valid=0 and never raise out_valid.
REQ-025 sum, c_out and ovf SHALL be registered outputs from the last stage, stable while out_valid=1 and out_ready=0.
REQ-026 Result SHALL equal (A + (sub ? ~B : B) + c_in) mod 2^(WIDTH+1) split as {c_out, sum}, for all operand values including all-ones wrap.
REQ-027 A simultaneous output-pop and input-accept in the same cycle SHALL be allowed with no beat lost or duplicated.
REQ-028 Beats SHALL emerge in acceptance order.

Reset
REQ-029 rst_n=0 SHALL immediately clear all valid bits, stage data and carry registers; out_valid=0, sum=0, c_out=0, ovf=0 while in reset.
REQ-030 in_ready SHALL read 1 during and after reset (pipeline empty).
REQ-031 Reset asserted mid-operation SHALL discard all in-flight beats; the first beat accepted after deassertion SHALL appear after exactly NSEG cycles.

Verification (WIDTH=64, SEG_WIDTH=16, NSEG=4)
REQ-032 Add: A=0x0000_0000_FFFF_FFFF, B=1, c_in=0, sub=0 -> 4 cycles later sum=0x0000_0001_0000_0000, c_out=0, ovf=0.
REQ-033 Wrap/sub: A=5, B=7, sub=1, c_in=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, c_out=0, ovf=0; A=all-ones, B=1, sub=0, c_in=0 -> sum=0, c_out=1.
REQ-034 Overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> sum=0x8000_0000_0000_0000, ovf=1, c_out=0.
REQ-035 Backpressure: 8 back-to-back beats, out_ready held 0 for 3 cycles mid-stream -> in_ready=0 during stall, outputs held, all 8 results correct and in order.
REQ-036 Bubbles: in_valid alternating 1/0 -> out_valid alternates 1/0 with 4-cycle offset.
REQ-037 Reset mid-flight: 3 beats accepted, rst_n pulsed low 1 cycle -> out_valid=0 and none of those beats ever emitted; a new beat after release emerges at cycle 4.
